// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM host bridge: command/response bundles,
// bus widths used by sdram_ctrl_if, and the issue FSM state encoding.
package sdram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int WORD_LEN   = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [WORD_LEN-1:0]   wstrb;
    } sdram_cmd_t;

    typedef struct packed {
        logic                  is_write;
        logic [DATA_WIDTH-1:0] rdata;
    } sdram_rsp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/sdram_ctrl_if.sv
// Request/completion bus between the host bridge and the SDRAM core.
// man: bridge side (drives rd/wr/addr/write_data); sub: core side.
interface sdram_ctrl_if;
    import sdram_pkg::*;

    logic                  rd;
    logic [WORD_LEN-1:0]   wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  rdy;
    logic                  rvalid;
    logic                  wvalid;
    logic                  error;

    modport man (
        output rd, wr, addr, write_data,
        input  rdy, rvalid, wvalid, read_data, error
    );

    modport sub (
        input  rd, wr, addr, write_data,
        output rdy, rvalid, wvalid, read_data, error
    );

endinterface

// File: rtl/sdram_sync_fifo.sv
// Generic synchronous FIFO with combinational head read.
// Ports: push/din in, pop/dout out, full/empty/count status.
module sdram_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    // A push while full lands in the slot being popped this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sdram_host_bridge.sv
// Host front-end for the SDRAM core: buffers commands, issues one at a time
// on ctrl_if, returns in-order completions. Ports: cmd_* in, rsp_* out, ctrl_if.
module sdram_host_bridge
    import sdram_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [WORD_LEN-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_is_write,
    sdram_ctrl_if.man             ctrl_if
);

    bridge_state_t state;
    logic          op_we;
    logic          proto_err;

    sdram_cmd_t cmd_in, cmd_head;
    sdram_rsp_t rsp_in, rsp_head;
    logic cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic [$clog2(RSP_DEPTH):0] rsp_count;
    logic credit_ok;
    logic rsp_match, rsp_stray;
    logic unused_ok;

    assign cmd_ready = !rst && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_pop   = (state == S_REQ) && ctrl_if.rdy;

    // Zero-strobe writes become full-word writes.
    assign cmd_in.we    = cmd_we;
    assign cmd_in.addr  = cmd_addr;
    assign cmd_in.wdata = cmd_wdata;
    assign cmd_in.wstrb = (cmd_we && cmd_wstrb == '0) ? '1 : cmd_wstrb;

    sdram_sync_fifo #(.WIDTH($bits(sdram_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .din   (cmd_in),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    // A slot is reserved before issue, so a completion always fits.
    assign credit_ok = !rsp_full || rsp_pop;

    assign rsp_match = op_we ? ctrl_if.wvalid : ctrl_if.rvalid;
    assign rsp_stray = op_we ? ctrl_if.rvalid : ctrl_if.wvalid;
    assign rsp_push  = (state == S_WAIT) && rsp_match;

    assign rsp_in.is_write = op_we;
    assign rsp_in.rdata    = op_we ? '0 : ctrl_if.read_data;

    sdram_sync_fifo #(.WIDTH($bits(sdram_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .pop   (rsp_pop),
        .din   (rsp_in),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_rdata    = rsp_valid ? rsp_head.rdata : '0;
    assign rsp_is_write = rsp_valid && rsp_head.is_write;

    assign unused_ok = &{1'b0, cmd_count, rsp_count, ctrl_if.error};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_we     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!cmd_empty && credit_ok) state <= S_REQ;
                end
                S_REQ: begin
                    if (ctrl_if.rdy) begin
                        op_we <= cmd_head.we;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_match) state <= S_IDLE;
                    if (rsp_stray) proto_err <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_if.rd         = 1'b0;
        ctrl_if.wr         = '0;
        ctrl_if.addr       = '0;
        ctrl_if.write_data = '0;
        if (state == S_REQ) begin
            ctrl_if.rd         = !cmd_head.we;
            ctrl_if.wr         = cmd_head.we ? cmd_head.wstrb : '0;
            ctrl_if.addr       = cmd_head.addr;
            ctrl_if.write_data = cmd_head.wdata;
        end
    end

endmodule

// File: doc/sdram_host_bridge.md
Name: sdram_host_bridge

Overview:
- Upstream front-end for the SDRAM core; the only block that drives the core's sdram_ctrl_if.
- Accepts host requests on a valid/ready command channel and buffers them in a command FIFO.
- Issues requests to the core one at a time, with a single request outstanding.
- Returns in-order read data and write acknowledgements on a valid/ready response channel, with credit-based backpressure so completions are never dropped.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of 2, ≥2.
- RSP_DEPTH, 4: response FIFO entries; power of 2, ≥2.
- Data, address and strobe widths are not parameters; they are taken from ctrl_if (DATA_WIDTH, ADDR_WIDTH, WORD_LEN).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: host command valid.
- cmd_ready, output, 1: bridge can accept a command (command FIFO not full).
- cmd_we, input, 1: 1 = write, 0 = read.
- cmd_addr, input, ADDR_WIDTH: byte address, passed unchanged to ctrl_if.addr.
- cmd_wdata, input, DATA_WIDTH: write data.
- cmd_wstrb, input, WORD_LEN: byte strobes; a write with all-zero strobes is forced to all-ones.
- rsp_valid, output, 1: response available.
- rsp_ready, input, 1: host accepts the response.
- rsp_rdata, output, DATA_WIDTH: read data; 0 for writes.
- rsp_is_write, output, 1: response is a write acknowledgement.
- ctrl_if, interface, sdram_ctrl_if.man: drives rd, wr, addr, write_data; samples rdy, rvalid, wvalid, read_data. error is ignored.

Behaviour:
- Command FIFO:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = !cmd_full; it is registered-state based and combinational on FIFO count only, never on cmd_valid.
  - Push and pop in the same cycle while full is allowed only if pop was already enabled; cmd_ready does not look ahead.
- Issue FSM states:
  - S_IDLE → S_REQ when the FIFO is non-empty AND (rsp_count + 1) ≤ RSP_DEPTH, counting a pending pop.
  - S_REQ:
    - Drive ctrl_if.rd = !we; ctrl_if.wr = we ? wstrb : 0; addr and write_data from the FIFO head.
    - Hold these until ctrl_if.rdy is sampled high. That cycle is the acceptance.
    - On acceptance: pop the head, record the op type, go to S_WAIT.
  - S_WAIT:
    - ctrl_if.rd = 0 and ctrl_if.wr = 0, always; they are never asserted the cycle after acceptance.
    - On rvalid (expected read): push {read_data, 0}.
    - On wvalid (expected write): push {0, 1}.
    - Then go to S_IDLE.
    - An rvalid/wvalid not matching the recorded op type is ignored and sets the sticky internal flag proto_err, visible for simulation assertions.
- Outside S_REQ, ctrl_if.rd, ctrl_if.wr, addr and write_data are all 0.
- Response credit: one slot is reserved at acceptance. The response FIFO can therefore never overflow, and a completion is always captured the same cycle it appears.
- Response FIFO:
  - rsp_valid = !rsp_empty.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop keeps the count unchanged.
- Latency:
  - Command to core request: the push cycle plus 1 when the FIFO was empty.
  - Completion to rsp_valid: 1 cycle (registered FIFO).
- Reset:
  - FSM → S_IDLE; both FIFOs emptied.
  - cmd_ready = 0 during rst, 1 the cycle after.
  - rsp_valid = 0, rsp_rdata = 0, rsp_is_write = 0.
  - ctrl_if.rd = 0, wr = 0, addr = 0, write_data = 0.
  - proto_err = 0.
  - Reset mid-operation: an outstanding core request is abandoned. Any later rvalid/wvalid is ignored because the FSM is in S_IDLE.
- Pointers: log2(DEPTH) + 1 bits; full/empty from MSB compare; wrap-around is natural.
- The core's boot and refresh periods (rdy low) simply extend S_REQ. No timeout.

Decomposition:
- sdram_pkg holds:
  - sdram_cmd_t {we, addr, wdata, wstrb};
  - sdram_rsp_t {is_write, rdata};
  - the bridge state enum.
- One generic sub-module, sdram_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated twice: command and response.

Test Plan:
- Single write, then read:
  - Stimulus: write addr 0x0000_0100, wdata 0xDEADBEEF, wstrb 4'hF, then a read of the same address.
  - Required: rsp (is_write = 1, rdata = 0), then rsp (is_write = 0, rdata = 0xDEADBEEF).
  - Required: ctrl_if.rd/wr high only while rdy = 0 plus the single acceptance cycle.
- Command FIFO full:
  - Stimulus: hold ctrl_if.rdy = 0 and push 5 commands back-to-back.
  - Required: cmd_ready drops after 4 accepted; the 5th waits.
  - Required: releasing rdy drains all 5, with responses in order.
- Response backpressure:
  - Stimulus: rsp_ready = 0 and issue 6 reads.
  - Required: exactly 4 core acceptances, then rd stays 0 and no completion is lost.
  - Required: raising rsp_ready yields all 6 responses in order.
- Zero strobe:
  - Stimulus: write with wstrb = 0.
  - Required: ctrl_if.wr = 4'hF.
- Mid-operation reset:
  - Stimulus: rst asserted in S_WAIT, and a stray rvalid 2 cycles later.
  - Required: no response is pushed, rsp_valid = 0, proto_err = 0.
- Protocol error:
  - Stimulus: read outstanding, model returns wvalid.
  - Required: proto_err = 1, no response pushed, FSM remains in S_WAIT until rvalid.
